// File: rtl/unary_adder_1_10.sv
// unary_adder_1_10 -- serial unary accumulator.
// Write mode: each 1 on stream A or stream B adds one to a WIDTH-bit counter.
// Read mode: the stored count is emitted on dout as a burst of 1s, one per
// unit, and the counter is drained as it goes.
// C is a sticky overflow flag. Only rst clears it.
// Build option: define UNARY_SATURATE_EN to make the counter saturate at
// 2^WIDTH-1 on overflow. Without it, the counter wraps around.
module unary_adder_1_10 #(
  parameter int WIDTH = 10
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic read_or_write,
  input  logic A,
  input  logic B,
  output logic dout,
  output logic C
);

  // Stored unit count. It is kept under this plain name so that it can be
  // read hierarchically.
  logic [WIDTH-1:0] count;
  logic             r_dout;
  logic             r_c;

  logic [1:0]       w_inc;
  logic [WIDTH:0]   w_next;
  logic             w_ovf;
  logic             w_count_nz;
  logic [WIDTH-1:0] w_wr_count;

  // The increment for this cycle is 0, 1 or 2. The sum is formed one bit
  // wider than the counter, so the carry out shows the overflow directly.
  assign w_inc      = {1'b0, A} + {1'b0, B};
  assign w_next     = {1'b0, count} + {{(WIDTH-1){1'b0}}, w_inc};
  assign w_ovf      = w_next[WIDTH];
  assign w_count_nz = |count;

`ifdef UNARY_SATURATE_EN
  // On overflow, clamp the count at the largest representable value.
  assign w_wr_count = w_ovf ? {WIDTH{1'b1}} : w_next[WIDTH-1:0];
`else
  // On overflow, drop the carry and keep the value modulo 2^WIDTH.
  assign w_wr_count = w_next[WIDTH-1:0];
`endif

  // State update. Reset comes first. en=0 freezes the count and C and
  // quietens dout. Write mode accumulates. Read mode drains one unit per cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      count  <= '0;
      r_dout <= 1'b0;
      r_c    <= 1'b0;
    end else if (!en) begin
      r_dout <= 1'b0;
    end else if (read_or_write) begin
      if (w_count_nz) begin
        r_dout <= 1'b1;
        count  <= count - 1'b1;
      end else begin
        r_dout <= 1'b0;
      end
    end else begin
      r_dout <= 1'b0;
      count  <= w_wr_count;
      if (w_ovf) begin
        r_c <= 1'b1;
      end
    end
  end

  assign dout = r_dout;
  assign C    = r_c;

endmodule

// File: tb/tb_unary_adder_1_10.sv
// Directed testbench for unary_adder_1_10.
// Expected values are hand-computed.
// Overflow expectations follow UNARY_SATURATE_EN when that macro is defined.
module tb_unary_adder_1_10;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic en = 1'b0;
  logic read_or_write = 1'b0;
  logic A = 1'b0;
  logic B = 1'b0;
  logic dout;
  logic C;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  unary_adder_1_10 #(.WIDTH(10)) dut (
    .clk           (clk),
    .rst           (rst),
    .en            (en),
    .read_or_write (read_or_write),
    .A             (A),
    .B             (B),
    .dout          (dout),
    .C             (C)
  );

  // Advance one rising edge, then settle past it before sampling.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  initial begin : stim
    int exp_cnt;
    int start_cnt;
    int ones;

    // Reset takes priority, even with both streams active and en=1.
    en = 1'b1; read_or_write = 1'b0; A = 1'b1; B = 1'b1;
    do_reset();
    check("reset_count", 16'(dut.count), 16'd0);
    check("reset_dout", 16'(dout), 16'd0);
    check("reset_c", 16'(C), 16'd0);

    // Accumulate: three cycles of A only, then two cycles of A and B.
    A = 1'b1; B = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      step();
      check("acc_single_count", 16'(dut.count), 16'(i));
      check("acc_single_dout", 16'(dout), 16'd0);
    end
    A = 1'b1; B = 1'b1;
    for (int i = 1; i <= 2; i++) begin
      step();
      check("acc_double_count", 16'(dut.count), 16'(3 + 2 * i));
      check("acc_double_dout", 16'(dout), 16'd0);
    end
    check("acc_c", 16'(C), 16'd0);
    $display("accumulate: count=%0d C=%0d", dut.count, C);

    // B alone adds one. While en=0, the count and C must not change.
    A = 1'b0; B = 1'b1;
    step();
    check("acc_b_only", 16'(dut.count), 16'd8);
    en = 1'b0; A = 1'b1;
    step();
    check("freeze_write_count", 16'(dut.count), 16'd8);
    en = 1'b1;

    // Overflow: 513 pairs of (A=B=1, A=B=0), starting from count 0.
    do_reset();
    for (int p = 1; p <= 513; p++) begin
      A = 1'b1; B = 1'b1;
      step();
      A = 1'b0; B = 1'b0;
      step();
      if (p == 511) begin
        check("ovf_511_count", 16'(dut.count), 16'd1022);
        check("ovf_511_c", 16'(C), 16'd0);
        $display("pair 511: count=%0d C=%0d", dut.count, C);
      end else if (p == 512) begin
`ifdef UNARY_SATURATE_EN
        check("ovf_512_count", 16'(dut.count), 16'd1023);
`else
        check("ovf_512_count", 16'(dut.count), 16'd0);
`endif
        check("ovf_512_c", 16'(C), 16'd1);
        $display("pair 512: count=%0d C=%0d", dut.count, C);
      end else if (p == 513) begin
`ifdef UNARY_SATURATE_EN
        check("ovf_513_count", 16'(dut.count), 16'd1023);
`else
        check("ovf_513_count", 16'(dut.count), 16'd2);
`endif
        check("ovf_513_c", 16'(C), 16'd1);
        $display("pair 513: count=%0d C=%0d", dut.count, C);
      end
    end

    // Read drain for 20 cycles. The stream inputs are held high to show
    // that read mode ignores them.
`ifdef UNARY_SATURATE_EN
    start_cnt = 1023;
`else
    start_cnt = 2;
`endif
    read_or_write = 1'b1; A = 1'b1; B = 1'b1;
    ones = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      check("drain_dout", 16'(dout), (i < start_cnt) ? 16'd1 : 16'd0);
      if (dout === 1'b1) ones++;
    end
    exp_cnt = (start_cnt > 20) ? start_cnt - 20 : 0;
    check("drain_count", 16'(dut.count), 16'(exp_cnt));
    check("drain_ones", 16'(ones), 16'((start_cnt > 20) ? 20 : start_cnt));
    check("drain_c_sticky", 16'(C), 16'd1);
    $display("drain: ones=%0d count=%0d C=%0d", ones, dut.count, C);

    // Freeze in read mode, then a reset in the middle of a read.
    read_or_write = 1'b0;
    do_reset();
    A = 1'b1; B = 1'b0;
    repeat (5) step();
    check("freeze_setup_count", 16'(dut.count), 16'd5);
    en = 1'b0; read_or_write = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("freeze_count", 16'(dut.count), 16'd5);
      check("freeze_dout", 16'(dout), 16'd0);
    end
    en = 1'b1;
    for (int i = 1; i <= 2; i++) begin
      step();
      check("midread_dout", 16'(dout), 16'd1);
      check("midread_count", 16'(dut.count), 16'(5 - i));
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("midrst_dout", 16'(dout), 16'd0);
    check("midrst_count", 16'(dut.count), 16'd0);
    check("midrst_c", 16'(C), 16'd0);
    step();
    check("empty_read_dout", 16'(dout), 16'd0);
    check("empty_read_count", 16'(dut.count), 16'd0);

    // Mode switching: write 3, read 1, then write resumes from 2.
    read_or_write = 1'b0; A = 1'b1; B = 1'b1;
    step();
    A = 1'b1; B = 1'b0;
    step();
    check("switch_write_count", 16'(dut.count), 16'd3);
    read_or_write = 1'b1;
    step();
    check("switch_read_dout", 16'(dout), 16'd1);
    check("switch_read_count", 16'(dut.count), 16'd2);
    read_or_write = 1'b0; A = 1'b0; B = 1'b1;
    step();
    check("switch_resume_count", 16'(dut.count), 16'd3);
    check("switch_resume_dout", 16'(dout), 16'd0);
    $display("mode switch: count=%0d", dut.count);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
